// File: rtl/wb_memory_slave.sv
// wb_memory_slave: Wishbone classic-cycle responder backed by a word-organised
// unified instruction/data RAM. A request is latched in IDLE, waits
// `waitstates` cycles in BUSY, terminates with ACK_O or ERR_O, and then holds
// that termination in HOLD until the master drops STB_I/CYC_I.
// Optional feature: define WB_MEM_ROPROTECT_EN to make the words below
// ROM_WORDS write-protected. A write there terminates with ERR_O.
module wb_memory_slave #(
    parameter int datawords  = 1024,
    parameter int datawidth  = 32,
    parameter int addrwidth  = 32,
    parameter int waitstates = 1,
    parameter int ROM_WORDS  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CYC_I,
    input  logic                 STB_I,
    input  logic                 WE_I,
    input  logic [3:0]           SEL_I,
    input  logic [addrwidth-1:0] ADR_I,
    input  logic [datawidth-1:0] DAT_I,
    output logic [datawidth-1:0] DAT_O,
    output logic                 ACK_O,
    output logic                 ERR_O
);

    localparam int                   IDXW      = (datawords > 1) ? $clog2(datawords) : 1;
    localparam logic [addrwidth-1:0] ADR_LIMIT = addrwidth'(datawords);
    localparam logic [IDXW:0]        ROM_LIMIT = (IDXW+1)'(ROM_WORDS);
    localparam logic [3:0]           WAIT_INIT = 4'(waitstates);

`ifdef WB_MEM_ROPROTECT_EN
    localparam logic ROPROT_EN = 1'b1;
`else
    localparam logic ROPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [datawidth-1:0] mem_r [datawords];

    // Request captured in IDLE. BUSY and HOLD work only from these copies.
    logic [IDXW-1:0]      idx_r;
    logic                 we_r;
    logic [3:0]           sel_r;
    logic [datawidth-1:0] wdat_r;
    logic                 oob_r;
    logic [3:0]           cnt_r;

    logic                 ack_r;
    logic                 err_r;
    logic [datawidth-1:0] rdat_r;

    logic                 req_s;
    logic                 latch_s;
    logic                 dec_s;
    logic                 done_s;
    logic                 release_s;
    logic                 fault_s;
    logic                 wr_en_s;

    // Next-state and control strobes. Aborts and releases follow CYC_I&STB_I.
    always_comb begin
        state_s   = state_r;
        latch_s   = 1'b0;
        dec_s     = 1'b0;
        done_s    = 1'b0;
        release_s = 1'b0;
        req_s     = CYC_I & STB_I;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    latch_s = 1'b1;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (cnt_r != 4'd0) begin
                    dec_s   = 1'b1;
                    state_s = BUSY;
                end else begin
                    done_s  = 1'b1;
                    state_s = HOLD;
                end
            end
            HOLD: begin
                if (!req_s) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // An error covers an out-of-range address and, when enabled, a write into the protected low region.
        fault_s = oob_r | (ROPROT_EN & we_r & ({1'b0, idx_r} < ROM_LIMIT));
        wr_en_s = done_s & we_r & ~fault_s;
    end

    // State, request capture, wait counter and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            we_r    <= 1'b0;
            sel_r   <= 4'd0;
            wdat_r  <= '0;
            oob_r   <= 1'b0;
            cnt_r   <= 4'd0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdat_r  <= '0;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                idx_r  <= ADR_I[IDXW-1:0];
                we_r   <= WE_I;
                sel_r  <= SEL_I;
                wdat_r <= DAT_I;
                oob_r  <= (ADR_I >= ADR_LIMIT);
                cnt_r  <= WAIT_INIT;
            end
            if (dec_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (done_s) begin
                if (fault_s) begin
                    err_r  <= 1'b1;
                    rdat_r <= '0;
                end else if (we_r) begin
                    ack_r  <= 1'b1;
                end else begin
                    ack_r  <= 1'b1;
                    rdat_r <= mem_r[idx_r];
                end
            end
            if (release_s) begin
                ack_r <= 1'b0;
                err_r <= 1'b0;
            end
        end
    end

    // Byte-lane RAM write on a successful write completion. Reset blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdat_r[8*i +: 8];
                end
            end
        end
    end

    assign DAT_O = rdat_r;
    assign ACK_O = ack_r;
    assign ERR_O = err_r;

endmodule

// File: tb/tb_wb_memory_slave.sv
// Directed testbench for wb_memory_slave.
// Instance 0: 1 wait state, no protected region.
// Instance 1: 3 wait states, no protected region.
// Instance 2: 1 wait state, ROM_WORDS=256, for the write-protect option.
module tb_wb_memory_slave;

    logic        clk = 1'b0;
    logic        rst_a  [3];
    logic        cyc_a  [3];
    logic        stb_a  [3];
    logic [31:0] dato_a [3];
    logic        ack_a  [3];
    logic        err_a  [3];
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] AE_ACK = 2'b10;
    localparam logic [1:0] AE_ERR = 2'b01;

    always #5 clk = ~clk;

    wb_memory_slave #(.waitstates(1), .ROM_WORDS(0)) u_ws1 (
        .clk(clk), .rst(rst_a[0]), .CYC_I(cyc_a[0]), .STB_I(stb_a[0]), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dato_a[0]), .ACK_O(ack_a[0]), .ERR_O(err_a[0]));

    wb_memory_slave #(.waitstates(3), .ROM_WORDS(0)) u_ws3 (
        .clk(clk), .rst(rst_a[1]), .CYC_I(cyc_a[1]), .STB_I(stb_a[1]), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dato_a[1]), .ACK_O(ack_a[1]), .ERR_O(err_a[1]));

    wb_memory_slave #(.waitstates(1), .ROM_WORDS(256)) u_rom (
        .clk(clk), .rst(rst_a[2]), .CYC_I(cyc_a[2]), .STB_I(stb_a[2]), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dato_a[2]), .ACK_O(ack_a[2]), .ERR_O(err_a[2]));

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_assert++;
        assert (obs !== bad) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected anything but %h", tag, obs, bad);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ae(input int d);
        return {30'd0, ack_a[d], err_a[d]};
    endfunction

    // Full cycle: checks exact latency, the held termination and the release.
    task automatic bus_cycle(input int d, input string tag, input logic w, input logic [31:0] a,
                             input logic [31:0] dv, input logic [3:0] s, input logic [1:0] exp_ae,
                             input logic [31:0] exp_dat, input bit chkd, input int hold);
        we = w; adr = a; dat = dv; sel = s;
        cyc_a[d] = 1'b1; stb_a[d] = 1'b1;
        for (int i = 0; i < ws_of(d) + 1; i++) begin
            tick();
            chk({tag, "/wait"}, ae(d), 32'd0);
        end
        tick();
        chk({tag, "/term"}, ae(d), {30'd0, exp_ae});
        if (chkd) chk({tag, "/dat"}, dato_a[d], exp_dat);
        // Bus inputs change while held. The slave must ignore them.
        adr = 32'h3; dat = 32'hCAFEF00D; we = ~w; sel = 4'hF;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "/hold_term"}, ae(d), {30'd0, exp_ae});
            if (chkd) chk({tag, "/hold_dat"}, dato_a[d], exp_dat);
        end
        cyc_a[d] = 1'b0; stb_a[d] = 1'b0;
        tick();
        chk({tag, "/release"}, ae(d), 32'd0);
        if (chkd) chk({tag, "/release_dat"}, dato_a[d], exp_dat);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_a[d] = 1'b1; cyc_a[d] = 1'b0; stb_a[d] = 1'b0;
        end
        we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset/term", ae(d), 32'd0);
            chk("reset/dat", dato_a[d], 32'd0);
            rst_a[d] = 1'b0;
        end
        tick();

        // 1 wait state: basic write/read, byte lanes, hold, errors
        bus_cycle(0, "w5_full",  1'b1, 32'd5, 32'hDEADBEEF, 4'b1111, AE_ACK, 32'h0,        1'b1, 0);
        bus_cycle(0, "r5_full",  1'b0, 32'd5, 32'h0,        4'b1111, AE_ACK, 32'hDEADBEEF, 1'b1, 0);
        bus_cycle(0, "w5_lane1", 1'b1, 32'd5, 32'h0000AA00, 4'b0010, AE_ACK, 32'hDEADBEEF, 1'b1, 0);
        bus_cycle(0, "r5_hold",  1'b0, 32'd5, 32'h0,        4'b0000, AE_ACK, 32'hDEADAAEF, 1'b1, 3);
        bus_cycle(0, "w0",       1'b1, 32'd0, 32'hA5A50000, 4'b1111, AE_ACK, 32'hDEADAAEF, 1'b1, 0);
        bus_cycle(0, "w1023",    1'b1, 32'd1023, 32'h01234567, 4'b1111, AE_ACK, 32'hDEADAAEF, 1'b1, 0);
        bus_cycle(0, "w1024",    1'b1, 32'd1024, 32'h12345678, 4'b1111, AE_ERR, 32'h0,     1'b1, 1);
        bus_cycle(0, "w_alias",  1'b1, 32'h80000005, 32'h0,   4'b1111, AE_ERR, 32'h0,        1'b1, 0);
        bus_cycle(0, "r0",       1'b0, 32'd0, 32'h0,        4'b1111, AE_ACK, 32'hA5A50000, 1'b1, 0);
        bus_cycle(0, "r1023",    1'b0, 32'd1023, 32'h0,     4'b1111, AE_ACK, 32'h01234567, 1'b1, 0);
        bus_cycle(0, "r1024",    1'b0, 32'd1024, 32'h0,     4'b1111, AE_ERR, 32'h0,        1'b1, 0);
        bus_cycle(0, "r5_noalias", 1'b0, 32'd5, 32'h0,      4'b1111, AE_ACK, 32'hDEADAAEF, 1'b1, 0);
        bus_cycle(0, "w5_sel0",  1'b1, 32'd5, 32'h0,        4'b0000, AE_ACK, 32'hDEADAAEF, 1'b1, 0);
        bus_cycle(0, "r5_sel0",  1'b0, 32'd5, 32'h0,        4'b1111, AE_ACK, 32'hDEADAAEF, 1'b1, 0);

        // 3 wait states: abort by dropping the strobe, then reset during BUSY
        bus_cycle(1, "ws3_w7",   1'b1, 32'd7, 32'h11223344, 4'b1111, AE_ACK, 32'h0,        1'b1, 0);
        bus_cycle(1, "ws3_r7",   1'b0, 32'd7, 32'h0,        4'b1111, AE_ACK, 32'h11223344, 1'b1, 0);
        we = 1'b1; adr = 32'd7; dat = 32'h00000055; sel = 4'b1111;
        cyc_a[1] = 1'b1; stb_a[1] = 1'b1;
        tick(); tick();
        cyc_a[1] = 1'b0; stb_a[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort/no_term", ae(1), 32'd0);
        end
        bus_cycle(1, "abort_r7", 1'b0, 32'd7, 32'h0,        4'b1111, AE_ACK, 32'h11223344, 1'b1, 0);

        we = 1'b1; adr = 32'd7; dat = 32'h00000055; sel = 4'b1111;
        cyc_a[1] = 1'b1; stb_a[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstbusy/wait", ae(1), 32'd0);
        end
        rst_a[1] = 1'b1;
        tick();
        chk("rstbusy/term", ae(1), 32'd0);
        chk("rstbusy/dat", dato_a[1], 32'd0);
        rst_a[1] = 1'b0; cyc_a[1] = 1'b0; stb_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstbusy/after", ae(1), 32'd0);
        end
        bus_cycle(1, "rstbusy_r7", 1'b0, 32'd7, 32'h0,      4'b1111, AE_ACK, 32'h11223344, 1'b1, 0);

        // Protected low region (ROM_WORDS=256)
`ifdef WB_MEM_ROPROTECT_EN
        bus_cycle(2, "rom_w10",  1'b1, 32'd10, 32'hFFFFFFFF, 4'b1111, AE_ERR, 32'h0, 1'b1, 0);
        bus_cycle(2, "rom_w255", 1'b1, 32'd255, 32'hDEAD0255, 4'b1111, AE_ERR, 32'h0, 1'b1, 0);
        bus_cycle(2, "rom_w256", 1'b1, 32'd256, 32'h00000256, 4'b1111, AE_ACK, 32'h0, 1'b1, 0);
        bus_cycle(2, "rom_r256", 1'b0, 32'd256, 32'h0, 4'b1111, AE_ACK, 32'h00000256, 1'b1, 0);
        bus_cycle(2, "rom_r10",  1'b0, 32'd10, 32'h0, 4'b1111, AE_ACK, 32'h0, 1'b0, 0);
        chk_ne("rom_r10/unwritten", dato_a[2], 32'hFFFFFFFF);
`else
        bus_cycle(2, "rom_w10",  1'b1, 32'd10, 32'hFFFFFFFF, 4'b1111, AE_ACK, 32'h0, 1'b1, 0);
        bus_cycle(2, "rom_r10",  1'b0, 32'd10, 32'h0, 4'b1111, AE_ACK, 32'hFFFFFFFF, 1'b1, 0);
        bus_cycle(2, "rom_w255", 1'b1, 32'd255, 32'hDEAD0255, 4'b1111, AE_ACK, 32'hFFFFFFFF, 1'b1, 0);
        bus_cycle(2, "rom_w256", 1'b1, 32'd256, 32'h00000256, 4'b1111, AE_ACK, 32'hFFFFFFFF, 1'b1, 0);
        bus_cycle(2, "rom_r256", 1'b0, 32'd256, 32'h0, 4'b1111, AE_ACK, 32'h00000256, 1'b1, 0);
        bus_cycle(2, "rom_r255", 1'b0, 32'd255, 32'h0, 4'b1111, AE_ACK, 32'hDEAD0255, 1'b1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_memory_slave.md
Name: wb_memory_slave

Overview:
- Wishbone classic-cycle responder: a word-organised unified instruction/data RAM serving the poliriscv_sc32 bus master.
- Answers fetch and load/store cycles with programmable wait states.
- Holds ACK_O/ERR_O until the master releases STB_I, matching the master's wait-for-ACK-low step.
- Sits on the same bus as the core; owns all program and data storage.

Parameters:
- datawords, 1024, number of 32-bit memory words.
- datawidth, 32, data bus width; must be 32.
- addrwidth, 32, width of ADR_I.
- waitstates, 1, extra cycles between request sampling and ACK_O; range 0-15.
- ROM_WORDS, 256, size of the write-protected low region; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- CYC_I  input  1  bus cycle valid.
- STB_I  input  1  strobe.
- WE_I  input  1  1 = write, 0 = read.
- SEL_I  input  4  byte-lane enables; bit i selects DAT bits 8i+7:8i.
- ADR_I  input  addrwidth  word address (word index, not byte address).
- DAT_I  input  datawidth  write data.
- DAT_O  output  datawidth  read data, registered.
- ACK_O  output  1  normal termination, registered.
- ERR_O  output  1  error termination, registered.

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, ACK_O=0, ERR_O=0, DAT_O=0, counter=0. RAM contents are not cleared. Reset overrides any in-flight cycle; a write still in BUSY is not performed.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - On an edge with CYC_I&STB_I=1: latch ADR_I, WE_I, SEL_I, DAT_I; set err_flag = (ADR_I >= datawords); counter=waitstates; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If CYC_I=0 or STB_I=0 at an edge: abort. No access, no ACK_O/ERR_O, go to IDLE.
  - Else if counter != 0: decrement counter.
  - Else (counter == 0), complete the access on that edge:
    - err_flag=1: ERR_O<=1, DAT_O<=0, no write.
    - Write: for each i with SEL latched bit i = 1, mem[adr][8i+7:8i] <= latched data byte i. ACK_O<=1. DAT_O unchanged.
    - Read: DAT_O<=mem[adr] (full word, SEL ignored). ACK_O<=1.
    - Go to HOLD.
- Latency: request sampled at edge N; ACK_O/ERR_O visible after edge N+waitstates+1.
- HOLD:
  - ACK_O (or ERR_O) and DAT_O held stable while CYC_I&STB_I=1, indefinitely.
  - First edge with STB_I=0 or CYC_I=0: ACK_O<=0, ERR_O<=0, go to IDLE.
  - A new request is sampled only in IDLE, so back-to-back cycles have a one-cycle minimum gap after STB_I falls.
- ACK_O and ERR_O are never high together.
- SEL_I=0000 write: terminates with ACK_O, memory unchanged.
- ADR_I bits above the RAM index are significant: any ADR_I >= datawords is an error, with no aliasing or wrap-around.
- Inputs arriving in BUSY/HOLD other than the CYC/STB drop are ignored; latched values are used.

Optional Feature:
- Macro WB_MEM_ROPROTECT_EN.
- Defined: a write with latched ADR < ROM_WORDS is treated like an error. ERR_O asserts with the same latency, no bytes are written. Reads of that region are unaffected.
- Undefined: the whole array is writable and ROM_WORDS is unused.

Test Plan:
- waitstates=1, rst, then write ADR=5, DAT=0xDEADBEEF, SEL=1111 (request edge N) -> ACK_O rises after edge N+2, ERR_O=0. Then read ADR=5 -> DAT_O=0xDEADBEEF with ACK_O.
- Write ADR=5, DAT=0x0000AA00, SEL=0010 -> ACK_O. Read ADR=5 -> 0xDEADAAEF.
- Read ADR=5 with STB_I held high 3 cycles after ACK_O -> ACK_O and DAT_O stay constant. STB_I low at edge M -> ACK_O=0 after edge M. Next request accepted only from IDLE.
- Write ADR=1024, DAT=0x12345678 -> ERR_O=1, ACK_O=0, DAT_O=0. Read ADR=0 and ADR=1023 -> contents unchanged.
- waitstates=3, write ADR=7, DAT=0x55; drop CYC_I/STB_I 2 cycles after request -> no ACK_O/ERR_O ever. Read ADR=7 -> prior value. Same test with rst pulsed in BUSY -> outputs 0, mem[7] unchanged.
- ROM_WORDS=256, write ADR=10, DAT=0xFFFFFFFF:
  - WB_MEM_ROPROTECT_EN defined -> ERR_O=1, mem[10] unchanged.
  - Undefined -> ACK_O=1, readback 0xFFFFFFFF.
